// File: rtl/neuron_feeder.sv
// neuron_feeder: collects (weight, x) pairs into vectors, fires the neuron, returns its result
module neuron_feeder #(
  parameter int NEURON_SIZE    = 4,
  parameter int WORD_SIZE      = 16,
  parameter int NEURON_LATENCY = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [WORD_SIZE-1:0]                  in_weight_i,
  input  logic [WORD_SIZE-1:0]                  in_x_i,
  output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_o,
  output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] x_o,
  output logic                                  en_o,
  input  logic [WORD_SIZE-1:0]                  result_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [WORD_SIZE-1:0]                  out_result_o
);
  localparam int IW = (NEURON_SIZE > 1) ? $clog2(NEURON_SIZE) : 1;
  localparam int LW = $clog2(NEURON_LATENCY + 1);
  typedef enum logic [1:0] {FILL, FIRE, WAIT, HOLD} state_t;
  state_t                                r_state;
  logic [IW-1:0]                         r_idx;
  logic [LW-1:0]                         r_lat;
  logic                                  r_rdy;
  logic                                  r_en;
  logic                                  r_ov;
  logic [WORD_SIZE-1:0]                  r_res;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] r_w;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] r_x;
  assign in_ready_o   = r_rdy;
  assign en_o         = r_en;
  assign out_valid_o  = r_ov;
  assign out_result_o = r_res;
  assign weights_o    = r_w;
  assign x_o          = r_x;
  // Sequencer: fill vectors, pulse enable, wait fixed latency, hold result until taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_lat   <= '0;
      r_rdy   <= 1'b0;
      r_en    <= 1'b0;
      r_ov    <= 1'b0;
      r_res   <= '0;
      r_w     <= '0;
      r_x     <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_rdy <= 1'b1;
          if (in_valid_i && r_rdy) begin
            r_w[r_idx] <= in_weight_i;
            r_x[r_idx] <= in_x_i;
            if (r_idx == IW'(NEURON_SIZE - 1)) begin
              r_idx   <= '0;
              r_rdy   <= 1'b0;
              r_en    <= 1'b1;
              r_state <= FIRE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        FIRE: begin
          r_en    <= 1'b0;
          r_lat   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_lat == LW'(NEURON_LATENCY - 1)) begin
            r_res   <= result_i;
            r_ov    <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            r_ov    <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
endmodule
